csr_excp_unit: RTL and testbench

Responder side of the ctrl↔CSR exception interface. It holds the LoongArch exception, timer and LL-bit CSRs. Each cycle it accepts at most one commit-stage event from ctrl: exception entry, ertn return, or CSR write. It updates the architectural state on the next edge and drives `crmd`/`ecfg`/`estat`/`era`/`eentry` back to ctrl for interrupt detection and redirect-PC selection.

---
 rtl/csr_excp_unit.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_csr_excp_unit.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_excp_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_excp_unit
// Description : LoongArch exception, timer and LL-bit CSRs answering the
//               commit-stage ctrl interface. The TID/TCFG/TVAL/TICLR timer
//               block is built only when CSR_TIMER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_excp_unit #(
    parameter logic [31:0] CORE_ID = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_exception,
    input  logic [31:0] exception_pc,
    input  logic [31:0] exception_addr,
    input  logic [5:0]  ecode,
    input  logic [8:0]  esubcode,
    input  logic        is_ertn,
    input  logic        csr_write_en,
    input  logic [13:0] csr_write_addr,
    input  logic [31:0] csr_write_data,
    input  logic [13:0] csr_read_addr,
    output logic [31:0] csr_read_data,
    input  logic        llbit_write_en,
    input  logic        llbit_write_data,
    input  logic [7:0]  hw_int,
    input  logic        ipi,
    output logic [31:0] crmd,
    output logic [31:0] prmd,
    output logic [31:0] ecfg,
    output logic [31:0] estat,
    output logic [31:0] era,
    output logic [31:0] eentry,
    output logic        llbit
);

    localparam logic [13:0] c_ADDR_CRMD   = 14'h000;
    localparam logic [13:0] c_ADDR_PRMD   = 14'h001;
    localparam logic [13:0] c_ADDR_ECFG   = 14'h004;
    localparam logic [13:0] c_ADDR_ESTAT  = 14'h005;
    localparam logic [13:0] c_ADDR_ERA    = 14'h006;
    localparam logic [13:0] c_ADDR_BADV   = 14'h007;
    localparam logic [13:0] c_ADDR_EENTRY = 14'h00C;
    localparam logic [13:0] c_ADDR_SAVE0  = 14'h030;
    localparam logic [13:0] c_ADDR_SAVE1  = 14'h031;
    localparam logic [13:0] c_ADDR_SAVE2  = 14'h032;
    localparam logic [13:0] c_ADDR_SAVE3  = 14'h033;
    localparam logic [13:0] c_ADDR_TID    = 14'h040;
    localparam logic [13:0] c_ADDR_TCFG   = 14'h041;
    localparam logic [13:0] c_ADDR_TVAL   = 14'h042;
    localparam logic [13:0] c_ADDR_TICLR  = 14'h044;
    localparam logic [13:0] c_ADDR_LLBCTL = 14'h060;

    localparam logic [8:0]  c_CRMD_RESET  = 9'h008;
    localparam logic [12:0] c_ECFG_MASK   = 13'h1BFF;
    localparam logic [5:0]  c_ECODE_ADE   = 6'h08;
    localparam logic [5:0]  c_ECODE_ALE   = 6'h09;

    // Architectural state, stored at the width of the implemented fields
    logic [8:0]  r_crmd;
    logic [2:0]  r_prmd;
    logic [12:0] r_ecfg;
    logic [1:0]  r_is_sw;
    logic [7:0]  r_is_hw;
    logic        r_is_ipi;
    logic [5:0]  r_ecode;
    logic [8:0]  r_esubcode;
    logic [31:0] r_era;
    logic [31:0] r_badv;
    logic [25:0] r_eentry;
    logic [31:0] r_save0;
    logic [31:0] r_save1;
    logic [31:0] r_save2;
    logic [31:0] r_save3;
    logic        r_llbit;
    logic        r_klo;

    logic        w_take_exc;
    logic        w_take_ertn;
    logic        w_take_wr;
    logic        w_wr_llbctl;
    logic        w_badv_pc;
    logic        w_badv_addr;
    logic        w_is_timer;
    logic [31:0] w_tid;
    logic [31:0] w_tcfg;
    logic [31:0] w_tval;
    logic [31:0] w_estat;
    logic [31:0] w_read_data;

    // One commit event per cycle: exception beats ertn beats a CSR write
    assign w_take_exc  = is_exception;
    assign w_take_ertn = is_ertn & ~is_exception;
    assign w_take_wr   = csr_write_en & ~is_exception & ~is_ertn;
    assign w_wr_llbctl = w_take_wr & (csr_write_addr == c_ADDR_LLBCTL);

    assign w_badv_pc   = (ecode == c_ECODE_ADE) && (esubcode == 9'd0);
    assign w_badv_addr = (ecode == c_ECODE_ALE) ||
                         ((ecode == c_ECODE_ADE) && (esubcode == 9'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crmd     <= c_CRMD_RESET;
            r_prmd     <= 3'd0;
            r_ecfg     <= 13'd0;
            r_is_sw    <= 2'd0;
            r_ecode    <= 6'd0;
            r_esubcode <= 9'd0;
            r_era      <= 32'd0;
            r_badv     <= 32'd0;
            r_eentry   <= 26'd0;
            r_save0    <= 32'd0;
            r_save1    <= 32'd0;
            r_save2    <= 32'd0;
            r_save3    <= 32'd0;
        end else if (w_take_exc) begin
            r_prmd      <= r_crmd[2:0];
            r_crmd[2:0] <= 3'b000;
            r_era       <= exception_pc;
            r_ecode     <= ecode;
            r_esubcode  <= esubcode;
            if (w_badv_pc) begin
                r_badv <= exception_pc;
            end else if (w_badv_addr) begin
                r_badv <= exception_addr;
            end
        end else if (w_take_ertn) begin
            r_crmd[2:0] <= r_prmd;
        end else if (w_take_wr) begin
            case (csr_write_addr)
                c_ADDR_CRMD:   r_crmd   <= csr_write_data[8:0];
                c_ADDR_PRMD:   r_prmd   <= csr_write_data[2:0];
                c_ADDR_ECFG:   r_ecfg   <= csr_write_data[12:0] & c_ECFG_MASK;
                c_ADDR_ESTAT:  r_is_sw  <= csr_write_data[1:0];
                c_ADDR_ERA:    r_era    <= csr_write_data;
                c_ADDR_BADV:   r_badv   <= csr_write_data;
                c_ADDR_EENTRY: r_eentry <= csr_write_data[31:6];
                c_ADDR_SAVE0:  r_save0  <= csr_write_data;
                c_ADDR_SAVE1:  r_save1  <= csr_write_data;
                c_ADDR_SAVE2:  r_save2  <= csr_write_data;
                c_ADDR_SAVE3:  r_save3  <= csr_write_data;
                default:       ;
            endcase
        end
    end

    // External interrupt lines are re-sampled every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_hw  <= 8'd0;
            r_is_ipi <= 1'b0;
        end else begin
            r_is_hw  <= hw_int;
            r_is_ipi <= ipi;
        end
    end

    // ll.w/sc.w updates outrank both the ertn clear and the WCLLB clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_llbit <= 1'b0;
            r_klo   <= 1'b0;
        end else begin
            if (llbit_write_en) begin
                r_llbit <= llbit_write_data;
            end else if (w_take_ertn && !r_klo) begin
                r_llbit <= 1'b0;
            end else if (w_wr_llbctl && csr_write_data[1]) begin
                r_llbit <= 1'b0;
            end

            if (w_take_ertn) begin
                r_klo <= 1'b0;
            end else if (w_wr_llbctl) begin
                r_klo <= csr_write_data[2];
            end
        end
    end

`ifdef CSR_TIMER_EN
    logic [31:0] r_tid;
    logic [31:0] r_tcfg;
    logic [31:0] r_tval;
    logic        r_is_timer;
    logic        w_timer_fire;
    logic        w_wr_tid;
    logic        w_wr_tcfg;
    logic        w_ticlr;

    assign w_wr_tid     = w_take_wr && (csr_write_addr == c_ADDR_TID);
    assign w_wr_tcfg    = w_take_wr && (csr_write_addr == c_ADDR_TCFG);
    assign w_ticlr      = w_take_wr && (csr_write_addr == c_ADDR_TICLR) && csr_write_data[0];
    assign w_timer_fire = r_tcfg[0] && (r_tval == 32'd0);

    // A TCFG write restarts the count and overrides this cycle's tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tid  <= CORE_ID;
            r_tcfg <= 32'd0;
            r_tval <= 32'd0;
        end else begin
            if (w_wr_tid) begin
                r_tid <= csr_write_data;
            end
            if (w_wr_tcfg) begin
                r_tcfg <= csr_write_data;
                r_tval <= {csr_write_data[31:2], 2'b00};
            end else if (r_tcfg[0]) begin
                if (r_tval != 32'd0) begin
                    r_tval <= r_tval - 32'd1;
                end else if (r_tcfg[1]) begin
                    r_tval <= {r_tcfg[31:2], 2'b00};
                end else begin
                    r_tcfg[0] <= 1'b0;
                end
            end
        end
    end

    // Expiry set wins over a TICLR clear on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_timer <= 1'b0;
        end else if (w_timer_fire) begin
            r_is_timer <= 1'b1;
        end else if (w_ticlr) begin
            r_is_timer <= 1'b0;
        end
    end

    assign w_tid      = r_tid;
    assign w_tcfg     = r_tcfg;
    assign w_tval     = r_tval;
    assign w_is_timer = r_is_timer;
`else
    logic w_unused_core_id;

    assign w_unused_core_id = ^CORE_ID;
    assign w_tid            = 32'd0;
    assign w_tcfg           = 32'd0;
    assign w_tval           = 32'd0;
    assign w_is_timer       = 1'b0;
`endif

    assign w_estat = {1'b0, r_esubcode, r_ecode, 3'b000, r_is_ipi, w_is_timer,
                      1'b0, r_is_hw, r_is_sw};

    always_comb begin
        w_read_data = 32'd0;
        case (csr_read_addr)
            c_ADDR_CRMD:   w_read_data = {23'd0, r_crmd};
            c_ADDR_PRMD:   w_read_data = {29'd0, r_prmd};
            c_ADDR_ECFG:   w_read_data = {19'd0, r_ecfg};
            c_ADDR_ESTAT:  w_read_data = w_estat;
            c_ADDR_ERA:    w_read_data = r_era;
            c_ADDR_BADV:   w_read_data = r_badv;
            c_ADDR_EENTRY: w_read_data = {r_eentry, 6'd0};
            c_ADDR_SAVE0:  w_read_data = r_save0;
            c_ADDR_SAVE1:  w_read_data = r_save1;
            c_ADDR_SAVE2:  w_read_data = r_save2;
            c_ADDR_SAVE3:  w_read_data = r_save3;
            c_ADDR_TID:    w_read_data = w_tid;
            c_ADDR_TCFG:   w_read_data = w_tcfg;
            c_ADDR_TVAL:   w_read_data = w_tval;
            c_ADDR_TICLR:  w_read_data = 32'd0;
            c_ADDR_LLBCTL: w_read_data = {29'd0, r_klo, 1'b0, r_llbit};
            default:       w_read_data = 32'd0;
        endcase
    end

    assign csr_read_data = w_read_data;
    assign crmd          = {23'd0, r_crmd};
    assign prmd          = {29'd0, r_prmd};
    assign ecfg          = {19'd0, r_ecfg};
    assign estat         = w_estat;
    assign era           = r_era;
    assign eentry        = {r_eentry, 6'd0};
    assign llbit         = r_llbit;

endmodule

`default_nettype wire

// File: tb/tb_csr_excp_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_excp_unit
// Description : Self-checking bench for csr_excp_unit: directed table, corner
//               sequences and a randomized run against a register-map model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_excp_unit;

    localparam logic [31:0] TB_CORE_ID = 32'h0000_0005;
`ifdef CSR_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        is_exception;
    logic [31:0] exception_pc;
    logic [31:0] exception_addr;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        is_ertn;
    logic        csr_write_en;
    logic [13:0] csr_write_addr;
    logic [31:0] csr_write_data;
    logic [13:0] csr_read_addr;
    logic [31:0] csr_read_data;
    logic        llbit_write_en;
    logic        llbit_write_data;
    logic [7:0]  hw_int;
    logic        ipi;
    logic [31:0] crmd, prmd, ecfg, estat, era, eentry;
    logic        llbit;

    int checks   = 0;
    int failures = 0;

    csr_excp_unit #(.CORE_ID(TB_CORE_ID)) dut (
        .clk(clk), .rst(rst),
        .is_exception(is_exception), .exception_pc(exception_pc),
        .exception_addr(exception_addr), .ecode(ecode), .esubcode(esubcode),
        .is_ertn(is_ertn),
        .csr_write_en(csr_write_en), .csr_write_addr(csr_write_addr),
        .csr_write_data(csr_write_data),
        .csr_read_addr(csr_read_addr), .csr_read_data(csr_read_data),
        .llbit_write_en(llbit_write_en), .llbit_write_data(llbit_write_data),
        .hw_int(hw_int), .ipi(ipi),
        .crmd(crmd), .prmd(prmd), .ecfg(ecfg), .estat(estat), .era(era),
        .eentry(eentry), .llbit(llbit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- register-map reference model ----------------
    logic [31:0] m [0:127];
    logic [31:0] n [0:127];
    logic        m_llb;
    logic        n_llb;

    function automatic bit mapped(input logic [13:0] a);
        case (a)
            14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007, 14'h00C,
            14'h030, 14'h031, 14'h032, 14'h033, 14'h060: return 1'b1;
            14'h040, 14'h041, 14'h042, 14'h044:          return TIMER_ON;
            default:                                     return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] wmask(input logic [13:0] a);
        case (a)
            14'h000: return 32'h0000_01FF;
            14'h001: return 32'h0000_0007;
            14'h004: return 32'h0000_1BFF;
            14'h005: return 32'h0000_0003;
            14'h00C: return 32'hFFFF_FFC0;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [13:0] a);
        if (!mapped(a))    return 32'd0;
        if (a == 14'h060)  return {29'd0, m[7'h60][2], 1'b0, m_llb};
        if (a == 14'h044)  return 32'd0;
        return m[a[6:0]];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m[i] = 32'd0;
        m[7'h00] = 32'h0000_0008;
        if (TIMER_ON) m[7'h40] = TB_CORE_ID;
        m_llb = 1'b0;
    endtask

    task automatic model_step();
        logic       fire;
        logic [6:0] a;
        logic [31:0] mk;
        n = m;
        n_llb = m_llb;
        fire = TIMER_ON && m[7'h41][0] && (m[7'h42] == 32'd0);
        if (TIMER_ON && m[7'h41][0]) begin
            if (m[7'h42] != 32'd0)   n[7'h42] = m[7'h42] - 32'd1;
            else if (m[7'h41][1])    n[7'h42] = {m[7'h41][31:2], 2'b00};
            else                     n[7'h41][0] = 1'b0;
        end
        if (fire) n[7'h05][11] = 1'b1;
        n[7'h05][9:2] = hw_int;
        n[7'h05][12]  = ipi;
        if (is_exception) begin
            n[7'h01] = m[7'h00] & 32'h7;
            n[7'h00] = m[7'h00] & ~32'h7;
            n[7'h06] = exception_pc;
            n[7'h05][21:16] = ecode;
            n[7'h05][30:22] = esubcode;
            if (ecode == 6'h08 && esubcode == 9'd0)
                n[7'h07] = exception_pc;
            else if (ecode == 6'h09 || (ecode == 6'h08 && esubcode == 9'd1))
                n[7'h07] = exception_addr;
        end else if (is_ertn) begin
            n[7'h00] = (m[7'h00] & ~32'h7) | (m[7'h01] & 32'h7);
            if (!m[7'h60][2]) n_llb = 1'b0;
            n[7'h60][2] = 1'b0;
        end else if (csr_write_en && mapped(csr_write_addr)) begin
            a  = csr_write_addr[6:0];
            mk = wmask(csr_write_addr);
            case (csr_write_addr)
                14'h041: begin
                    n[a] = csr_write_data;
                    n[7'h42] = {csr_write_data[31:2], 2'b00};
                end
                14'h042: ;
                14'h044: if (csr_write_data[0] && !fire) n[7'h05][11] = 1'b0;
                14'h060: begin
                    if (csr_write_data[1]) n_llb = 1'b0;
                    n[a] = csr_write_data & 32'h4;
                end
                default: n[a] = (n[a] & ~mk) | (csr_write_data & mk);
            endcase
        end
        if (llbit_write_en) n_llb = llbit_write_data;
        m = n;
        m_llb = n_llb;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        is_exception = 1'b0; exception_pc = '0; exception_addr = '0;
        ecode = '0; esubcode = '0; is_ertn = 1'b0;
        csr_write_en = 1'b0; csr_write_addr = '0; csr_write_data = '0;
        llbit_write_en = 1'b0; llbit_write_data = 1'b0; hw_int = '0; ipi = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic csr_wr(input logic [13:0] a, input logic [31:0] d);
        csr_write_en = 1'b1; csr_write_addr = a; csr_write_data = d;
        step();
    endtask

    task automatic chk_rd(input logic [13:0] a, input logic [31:0] exp, input string name);
        csr_read_addr = a;
        #1;
        check(name, csr_read_data, exp);
    endtask

    task automatic raise_exc(input logic [31:0] pc, input logic [31:0] addr,
                             input logic [5:0] ec, input logic [8:0] sub);
        is_exception = 1'b1; exception_pc = pc; exception_addr = addr;
        ecode = ec; esubcode = sub;
        step();
    endtask

    // Reset asserted between edges so its asynchronous effect is observed
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle();
        #1;
        check("rst_crmd", crmd, 32'h0000_0008);
        check("rst_prmd", prmd, 32'd0);
        check("rst_ecfg", ecfg, 32'd0);
        check("rst_estat", estat, 32'd0);
        check("rst_era", era, 32'd0);
        check("rst_eentry", eentry, 32'd0);
        check("rst_llbit", {31'd0, llbit}, 32'd0);
        chk_rd(14'h007, 32'd0, "rst_badv");
        chk_rd(14'h042, 32'd0, "rst_tval");
`ifdef CSR_TIMER_EN
        chk_rd(14'h040, TB_CORE_ID, "rst_tid");
`else
        chk_rd(14'h040, 32'd0, "rst_tid");
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [0:11];
    logic [13:0] pool [0:19];

    initial begin
        rst = 1'b1;
        idle();
        csr_read_addr = '0;

        tbl[0]  = '{14'h005, 32'hFFFF_FFFF, 32'h0000_0003};
        tbl[1]  = '{14'h00C, 32'hFFFF_FFFF, 32'hFFFF_FFC0};
        tbl[2]  = '{14'h000, 32'hFFFF_FFFF, 32'h0000_01FF};
        tbl[3]  = '{14'h001, 32'hFFFF_FFFF, 32'h0000_0007};
        tbl[4]  = '{14'h004, 32'hFFFF_FFFF, 32'h0000_1BFF};
        tbl[5]  = '{14'h032, 32'h1234_5678, 32'h1234_5678};
        tbl[6]  = '{14'h003, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[7]  = '{14'h060, 32'hFFFF_FFFF, 32'h0000_0004};
        tbl[8]  = '{14'h044, 32'hFFFF_FFFF, 32'h0000_0000};
`ifdef CSR_TIMER_EN
        tbl[9]  = '{14'h040, 32'h0000_ABCD, 32'h0000_ABCD};
`else
        tbl[9]  = '{14'h040, 32'h0000_ABCD, 32'h0000_0000};
`endif
        tbl[10] = '{14'h042, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[11] = '{14'h007, 32'hCAFE_F00D, 32'hCAFE_F00D};

        pool = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007, 14'h00C,
                 14'h030, 14'h031, 14'h032, 14'h033, 14'h040, 14'h041, 14'h042,
                 14'h044, 14'h060, 14'h002, 14'h043, 14'h061, 14'h3FFF};

        do_reset();

        // Write masks and read-only / unmapped behaviour
        for (int i = 0; i < 12; i++) begin
            csr_read_addr = tbl[i].addr;
            csr_wr(tbl[i].addr, tbl[i].wdata);
            #1;
            check($sformatf("tbl[%0d]", i), csr_read_data, tbl[i].exp);
        end

        do_reset();

        // Read during write returns the old value
        csr_read_addr = 14'h030;
        csr_write_en = 1'b1; csr_write_addr = 14'h030; csr_write_data = 32'h0000_0011;
        #1;
        check("rdw_old", csr_read_data, 32'd0);
        step();
        chk_rd(14'h030, 32'h0000_0011, "rdw_new");

        // Exception entry with a same-cycle ERA write that must be dropped
        csr_wr(14'h000, 32'h0000_0007);
        is_exception = 1'b1; exception_pc = 32'h1C00_0100; exception_addr = 32'h0000_1234;
        ecode = 6'h09; esubcode = 9'd0;
        csr_write_en = 1'b1; csr_write_addr = 14'h006; csr_write_data = 32'hDEAD_BEEF;
        step();
        check("exc_crmd_plvie", crmd & 32'h7, 32'd0);
        check("exc_prmd", prmd, 32'h0000_0007);
        check("exc_era", era, 32'h1C00_0100);
        check("exc_ecode", {26'd0, estat[21:16]}, 32'h9);
        chk_rd(14'h007, 32'h0000_1234, "exc_badv_ale");

        is_ertn = 1'b1;
        step();
        check("ertn_crmd", crmd & 32'h7, 32'h7);

        // BADV source selection
        raise_exc(32'h1C00_0200, 32'h0000_5555, 6'h08, 9'd0);
        chk_rd(14'h007, 32'h1C00_0200, "badv_adef");
        raise_exc(32'h1C00_0300, 32'h0000_7777, 6'h08, 9'd1);
        chk_rd(14'h007, 32'h0000_7777, "badv_adem");
        raise_exc(32'h1C00_0400, 32'h0000_9999, 6'h03, 9'd0);
        chk_rd(14'h007, 32'h0000_7777, "badv_other");
        check("era_other", era, 32'h1C00_0400);

        // LL bit and KLO
        llbit_write_en = 1'b1; llbit_write_data = 1'b1;
        step();
        check("llbit_set", {31'd0, llbit}, 32'h1);
        is_ertn = 1'b1;
        step();
        check("ertn_llbit_clr", {31'd0, llbit}, 32'h0);
        csr_wr(14'h060, 32'h0000_0004);
        llbit_write_en = 1'b1; llbit_write_data = 1'b1;
        step();
        is_ertn = 1'b1;
        step();
        check("ertn_klo_keep", {31'd0, llbit}, 32'h1);
        chk_rd(14'h060, 32'h0000_0001, "llbctl_klo_cleared");
        llbit_write_en = 1'b1; llbit_write_data = 1'b1;
        csr_write_en = 1'b1; csr_write_addr = 14'h060; csr_write_data = 32'h2;
        step();
        check("llbit_we_over_wcllb", {31'd0, llbit}, 32'h1);
        csr_wr(14'h060, 32'h0000_0002);
        check("wcllb_clr", {31'd0, llbit}, 32'h0);

`ifdef CSR_TIMER_EN
        // One-shot: InitVal=2 -> counts 8..0, then fires and disables
        csr_wr(14'h041, 32'h0000_0009);
        for (int k = 0; k <= 8; k++) begin
            chk_rd(14'h042, 32'(8 - k), "oneshot_tval");
            check("oneshot_is11_low", {31'd0, estat[11]}, 32'd0);
            step();
        end
        check("oneshot_is11_set", {31'd0, estat[11]}, 32'h1);
        chk_rd(14'h041, 32'h0000_0008, "oneshot_en_off");
        chk_rd(14'h042, 32'd0, "oneshot_tval_zero");
        step();
        chk_rd(14'h042, 32'd0, "oneshot_tval_hold");
        csr_wr(14'h044, 32'h0000_0001);
        check("ticlr_clear", {31'd0, estat[11]}, 32'd0);

        // Periodic: fires every 9 cycles, reloads 8
        csr_wr(14'h041, 32'h0000_000B);
        repeat (8) step();
        chk_rd(14'h042, 32'd0, "per_tval_zero");
        check("per_is11_before", {31'd0, estat[11]}, 32'd0);
        step();
        check("per_is11_first", {31'd0, estat[11]}, 32'h1);
        chk_rd(14'h042, 32'h0000_0008, "per_reload1");
        csr_wr(14'h044, 32'h0000_0001);
        check("per_clr", {31'd0, estat[11]}, 32'd0);
        repeat (7) step();
        chk_rd(14'h042, 32'd0, "per_tval_zero2");
        check("per_is11_still_low", {31'd0, estat[11]}, 32'd0);
        csr_wr(14'h044, 32'h0000_0001);
        check("per_set_beats_clr", {31'd0, estat[11]}, 32'h1);
        chk_rd(14'h042, 32'h0000_0008, "per_reload2");
        repeat (3) step();
`else
        csr_wr(14'h041, 32'h0000_000B);
        repeat (12) step();
        chk_rd(14'h041, 32'd0, "notimer_tcfg");
        chk_rd(14'h042, 32'd0, "notimer_tval");
        check("notimer_is11", {31'd0, estat[11]}, 32'd0);
`endif

        // Reset while the timer may be counting
        do_reset();
        model_reset();

        for (int c = 0; c < 1500; c++) begin
            is_exception   = ($urandom_range(0, 15) == 0);
            exception_pc   = $urandom;
            exception_addr = $urandom;
            case ($urandom_range(0, 3))
                0:       ecode = 6'h08;
                1:       ecode = 6'h09;
                default: ecode = 6'($urandom);
            endcase
            esubcode       = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 1)) : 9'($urandom);
            is_ertn        = ($urandom_range(0, 15) == 0);
            csr_write_en   = ($urandom_range(0, 2) == 0);
            csr_write_addr = pool[$urandom_range(0, 19)];
            csr_write_data = $urandom;
            if (csr_write_addr == 14'h041)
                csr_write_data = (32'($urandom_range(0, 12)) << 2) | 32'($urandom_range(0, 3));
            llbit_write_en   = ($urandom_range(0, 7) == 0) && !is_ertn;
            llbit_write_data = 1'($urandom_range(0, 1));
            hw_int           = 8'($urandom);
            ipi              = 1'($urandom_range(0, 1));
            csr_read_addr    = pool[$urandom_range(0, 19)];
            #1;
            check("rnd_crmd", crmd, m[7'h00]);
            check("rnd_prmd", prmd, m[7'h01]);
            check("rnd_ecfg", ecfg, m[7'h04]);
            check("rnd_estat", estat, m[7'h05]);
            check("rnd_era", era, m[7'h06]);
            check("rnd_eentry", eentry, m[7'h0C]);
            check("rnd_llbit", {31'd0, llbit}, {31'd0, m_llb});
            check($sformatf("rnd_read_%03h", csr_read_addr), csr_read_data, model_read(csr_read_addr));
            model_step();
            @(negedge clk);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
